spawn_sequencer: RTL and testbench

Sequences the 7-bag `generate_tetromino` block and owns the hold slot. On a request from the game FSM it pulses the generator, waits out the generator latency, and captures the new active piece and preview. It then has the collision checker test the spawn position and either issues the piece or raises game-over. It sits between the game FSM, `generate_tetromino` and the board collision checker.

---
 rtl/spawn_sequencer_pkg.sv | 20 ++
 rtl/spawn_sequencer_hold_slot.sv | 37 +++
 rtl/spawn_sequencer.sv | 104 ++++++++++
 tb/tb_spawn_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/spawn_sequencer_pkg.sv
// spawn_sequencer_pkg: tetromino types, piece indices and spawn FSM states
package spawn_sequencer_pkg;
    localparam logic [2:0] TETROMINO_I_IDX = 3'd1;
    localparam logic [2:0] TETROMINO_J_IDX = 3'd2;
    localparam logic [2:0] TETROMINO_L_IDX = 3'd3;
    localparam logic [2:0] TETROMINO_O_IDX = 3'd4;
    localparam logic [2:0] TETROMINO_S_IDX = 3'd5;
    localparam logic [2:0] TETROMINO_T_IDX = 3'd6;
    localparam logic [2:0] TETROMINO_Z_IDX = 3'd7;
    typedef struct packed {
        logic [2:0] data;
    } tetromino_idx_t;
    typedef struct packed {
        tetromino_idx_t idx;
        logic [15:0]    shape;
    } tetromino_ctrl;
    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_WAIT, S_CHECK, S_SPAWN, S_ACTIVE, S_OVER
    } spawn_state_e;
endpackage

// File: rtl/spawn_sequencer_hold_slot.sv
// hold_slot: held piece register, valid/used flags and the swap mux
module hold_slot
    import spawn_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_used,
    input  logic          hold_en,
    input  tetromino_ctrl cur_in,
    output tetromino_ctrl cur_sel,
    output tetromino_ctrl hold_out,
    output logic          hold_valid,
    output logic          hold_used
);
    tetromino_ctrl hold_q, hold_d;
    logic          valid_q, valid_d, used_q, used_d;
    always_comb begin
        hold_d  = hold_en ? cur_in : hold_q;
        valid_d = valid_q | hold_en;
        used_d  = hold_en ? 1'b1 : clr_used ? 1'b0 : used_q;
        cur_sel = (hold_en && valid_q) ? hold_q : cur_in;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
            used_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
            used_q  <= used_d;
        end
    end
    assign hold_out   = hold_q;
    assign hold_valid = valid_q;
    assign hold_used  = used_q;
endmodule

// File: rtl/spawn_sequencer.sv
// spawn_sequencer: sequences the bag generator, spawn check and hold slot
module spawn_sequencer
    import spawn_sequencer_pkg::*;
#(
    parameter int GEN_LATENCY = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spawn_req,
    input  logic          hold_req,
    output logic          gen_enable,
    input  tetromino_ctrl gen_curr,
    input  tetromino_ctrl gen_next,
    output logic          chk_valid,
    output tetromino_ctrl chk_piece,
    input  logic          chk_blocked,
    output tetromino_ctrl piece_out,
    output logic          piece_valid,
    output tetromino_ctrl next_out,
    output tetromino_ctrl hold_out,
    output logic          hold_valid,
    output logic          hold_used,
    output logic          busy,
    output logic          game_over
);
    spawn_state_e  state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    tetromino_ctrl cur_q, cur_d, next_q, next_d, piece_q, piece_d, cur_sel;
    logic          clr_used, hold_en;
    hold_slot u_hold (
        .clk        (clk),
        .rst        (rst),
        .clr_used   (clr_used),
        .hold_en    (hold_en),
        .cur_in     (cur_q),
        .cur_sel    (cur_sel),
        .hold_out   (hold_out),
        .hold_valid (hold_valid),
        .hold_used  (hold_used)
    );
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        next_d   = next_q;
        piece_d  = piece_q;
        clr_used = 1'b0;
        hold_en  = 1'b0;
        case (state_q)
            S_IDLE, S_ACTIVE: begin
                if (spawn_req) begin
                    state_d  = S_GEN;
                    clr_used = 1'b1;
                end else if (state_q == S_ACTIVE && hold_req && !hold_used) begin
                    hold_en = 1'b1;
                    cur_d   = cur_sel;
                    state_d = hold_valid ? S_CHECK : S_GEN;
                end
            end
            S_GEN: begin
                cnt_d   = 4'(GEN_LATENCY - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    cur_d   = gen_curr;
                    next_d  = gen_next;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CHECK: begin
                state_d = chk_blocked ? S_OVER : S_SPAWN;
                piece_d = chk_blocked ? piece_q : cur_q;
            end
            S_SPAWN: state_d = S_ACTIVE;
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cur_q   <= '0;
            next_q  <= '0;
            piece_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            next_q  <= next_d;
            piece_q <= piece_d;
        end
    end
    assign gen_enable  = state_q == S_GEN;
    assign chk_valid   = state_q == S_CHECK;
    assign chk_piece   = cur_q;
    assign piece_valid = state_q == S_SPAWN;
    assign piece_out   = piece_q;
    assign next_out    = next_q;
    assign game_over   = state_q == S_OVER;
    assign busy        = !(state_q == S_IDLE || state_q == S_ACTIVE || state_q == S_OVER);
endmodule

// File: tb/tb_spawn_sequencer.sv
// tb_spawn_sequencer: table-driven cycle vectors plus a bounded spawn-latency sequence
module tb_spawn_sequencer;
    import spawn_sequencer_pkg::*;
    localparam int GL = 3;
    localparam tetromino_ctrl JUNK = {3'd0, 16'hFFFF};
    typedef struct {
        logic       rn, sp, ho, bl;
        logic [6:0] flags;
        int         ep, en, eh, ec;
    } vec_t;
    logic          clk = 1'b0;
    logic          rst, spawn_req, hold_req, chk_blocked;
    logic          gen_enable, chk_valid, piece_valid, hold_valid, hold_used, busy, game_over;
    tetromino_ctrl gen_curr, gen_next, chk_piece, piece_out, next_out, hold_out;
    int            checks = 0, failures = 0;
    int            bag = 0, cur_k = 0;
    logic [3:0]    gcnt = '0;
    vec_t          tbl[$];
    always #5 clk = ~clk;
    spawn_sequencer #(.GEN_LATENCY(GL)) dut (
        .clk         (clk),
        .rst         (rst),
        .spawn_req   (spawn_req),
        .hold_req    (hold_req),
        .gen_enable  (gen_enable),
        .gen_curr    (gen_curr),
        .gen_next    (gen_next),
        .chk_valid   (chk_valid),
        .chk_piece   (chk_piece),
        .chk_blocked (chk_blocked),
        .piece_out   (piece_out),
        .piece_valid (piece_valid),
        .next_out    (next_out),
        .hold_out    (hold_out),
        .hold_valid  (hold_valid),
        .hold_used   (hold_used),
        .busy        (busy),
        .game_over   (game_over)
    );
    function automatic tetromino_ctrl mk(int k);
        tetromino_ctrl t;
        t.idx.data = 3'(k % 7 + 1);
        case (k % 7)
            0: t.shape = 16'h0F00;
            1: t.shape = 16'h8E00;
            2: t.shape = 16'h2E00;
            3: t.shape = 16'h6600;
            4: t.shape = 16'h6C00;
            5: t.shape = 16'h4E00;
            default: t.shape = 16'hC600;
        endcase
        return t;
    endfunction
    function automatic tetromino_ctrl ref_piece(int code);
        return code == -2 ? tetromino_ctrl'('0) : mk(code);
    endfunction
    always @(posedge clk) begin
        if (gen_enable) begin
            cur_k <= bag;
            bag   <= bag + 1;
            gcnt  <= 4'(GL);
        end else if (gcnt != 0) begin
            gcnt <= gcnt - 4'd1;
        end
    end
    assign gen_curr = (gcnt == 4'd1) ? mk(cur_k) : JUNK;
    assign gen_next = (gcnt == 4'd1) ? mk(cur_k + 1) : JUNK;
    task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h want %h", nm, i, act, exp);
        end
    endtask
    task automatic add(input logic rn, sp, ho, bl, input logic [6:0] f,
                       input int ep = -1, input int en = -1, input int eh = -1, input int ec = -1);
        vec_t v;
        v.rn = rn; v.sp = sp; v.ho = ho; v.bl = bl; v.flags = f;
        v.ep = ep; v.en = en; v.eh = eh; v.ec = ec;
        tbl.push_back(v);
    endtask
    function automatic logic piece_ok(tetromino_ctrl t);
        return t.idx.data >= TETROMINO_I_IDX && t.idx.data <= TETROMINO_Z_IDX && t.shape != 16'h0;
    endfunction
    initial begin
        int n;
        // flags = {gen_enable, chk_valid, piece_valid, busy, game_over, hold_valid, hold_used}
        add(1, 1, 0, 0, 7'b0000000);
        add(1, 0, 0, 0, 7'b1001000);
        add(1, 0, 0, 0, 7'b0001000);
        add(1, 0, 0, 0, 7'b0001000);
        add(1, 0, 0, 0, 7'b0001000);
        add(1, 0, 0, 0, 7'b0101000, -1, -1, -1, 0);
        add(1, 0, 0, 0, 7'b0011000, 0, 1);
        add(1, 0, 1, 0, 7'b0000000);
        add(1, 0, 0, 0, 7'b1001011, -1, -1, 0);
        add(1, 0, 0, 0, 7'b0001011);
        add(1, 0, 0, 0, 7'b0001011);
        add(1, 0, 0, 0, 7'b0001011);
        add(1, 0, 0, 0, 7'b0101011, -1, -1, -1, 1);
        add(1, 0, 0, 0, 7'b0011011, 1, 2, 0);
        add(1, 0, 1, 0, 7'b0000011);
        add(1, 0, 0, 0, 7'b0000011, 1, 2, 0);
        add(1, 1, 0, 0, 7'b0000011);
        add(1, 0, 0, 0, 7'b1001010);
        add(1, 0, 0, 0, 7'b0001010);
        add(1, 0, 0, 0, 7'b0001010);
        add(1, 0, 0, 0, 7'b0001010);
        add(1, 0, 0, 0, 7'b0101010, -1, -1, -1, 2);
        add(1, 0, 0, 0, 7'b0011010, 2, 3, 0);
        add(1, 0, 1, 0, 7'b0000010);
        add(1, 0, 0, 0, 7'b0101011, -1, -1, 2, 0);
        add(1, 0, 0, 0, 7'b0011011, 0, 3, 2);
        add(1, 1, 1, 0, 7'b0000011);
        add(1, 0, 0, 0, 7'b1001010, -1, -1, 2);
        add(1, 1, 0, 0, 7'b0001010);
        add(1, 0, 0, 0, 7'b0001010);
        add(1, 0, 0, 0, 7'b0001010);
        add(1, 0, 0, 1, 7'b0101010, -1, -1, 2, 3);
        add(1, 1, 1, 0, 7'b0000110, 0);
        add(1, 1, 0, 0, 7'b0000110, 0);
        add(0, 0, 0, 0, 7'b0000110);
        add(1, 1, 0, 0, 7'b0000000, -2, -2, -2, -2);
        add(0, 0, 0, 0, 7'b1001000);
        add(1, 1, 0, 0, 7'b0000000, -2, -2, -2, -2);
        add(1, 0, 0, 0, 7'b1001000);
        add(0, 0, 0, 0, 7'b0001000);
        add(1, 0, 0, 0, 7'b0000000, -2, -2, -2, -2);
        add(1, 0, 0, 0, 7'b0000000);
        rst = 1'b0; spawn_req = 1'b0; hold_req = 1'b0; chk_blocked = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", -1, {gen_enable, chk_valid, piece_valid, busy, game_over, hold_valid, hold_used}, 0);
        check("reset_piece", -1, piece_out, 0);
        check("reset_next", -1, next_out, 0);
        check("reset_hold", -1, hold_out, 0);
        check("reset_chk_piece", -1, chk_piece, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rn; spawn_req = tbl[i].sp; hold_req = tbl[i].ho; chk_blocked = tbl[i].bl;
            #1;
            check("flags", i, {gen_enable, chk_valid, piece_valid, busy, game_over, hold_valid, hold_used}, tbl[i].flags);
            if (tbl[i].ep != -1) check("piece_out", i, piece_out, ref_piece(tbl[i].ep));
            if (tbl[i].en != -1) check("next_out", i, next_out, ref_piece(tbl[i].en));
            if (tbl[i].eh != -1) check("hold_out", i, hold_out, ref_piece(tbl[i].eh));
            if (tbl[i].ec != -1) check("chk_piece", i, chk_piece, ref_piece(tbl[i].ec));
            if (tbl[i].flags[4]) check("piece_range", i, piece_ok(piece_out), 1);
            @(posedge clk);
            #1;
        end
        rst = 1'b1; spawn_req = 1'b1; hold_req = 1'b0; chk_blocked = 1'b0;
        @(posedge clk);
        #1;
        spawn_req = 1'b0;
        n = 1;
        while (!piece_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("spawn_latency", -1, n, 3 + GL);
        check("latency_piece_range", -1, piece_ok(piece_out), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
